mul_writeback: RTL and testbench

MUL_WRITEBACK -- requirements
Module: mul_writeback

---
 rtl/mul_writeback.sv | 74 +++++++
 tb/tb_mul_writeback.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul_writeback.sv
// Writeback-stage register for the multiplier: selects the architectural result
// from the double-width product and counts retired multiplies.
module mul_writeback #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic [2*XLEN-1:0] ProdM,
  input  logic [2:0]        Funct3M,
  input  logic              W64M,
  input  logic              MulValidM,
  output logic [XLEN-1:0]   MulResultW,
  output logic              MulValidW,
  output logic [31:0]       MulCountW
);

  localparam int unsigned CNT_W = 32;

  logic [XLEN-1:0]  sel_result_c;
  logic             sel_valid_c;
  logic             is_word_c;
  logic             capture_c;
  logic [XLEN-1:0]  result_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;

  // Word ops only exist on a 64-bit datapath and only for the low-half mul
  assign is_word_c = (XLEN == 64) && W64M && (Funct3M == 3'b000);

  always_comb begin
    sel_result_c = '0;
    sel_valid_c  = 1'b0;
    if (!Funct3M[2]) begin
      sel_valid_c = MulValidM;
      if (is_word_c)
        sel_result_c = XLEN'($signed(ProdM[31:0]));
      else if (Funct3M[1:0] == 2'b00)
        sel_result_c = ProdM[XLEN-1:0];
      else
        sel_result_c = ProdM[2*XLEN-1:XLEN];
    end
  end

  assign capture_c = !FlushW && !StallW;

  // Writeback register: flush beats stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (FlushW) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (!StallW) begin
      result_q <= sel_result_c;
      valid_q  <= sel_valid_c;
    end
  end

  // Retirement counter; wraps silently, never cleared by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else if (capture_c && sel_valid_c)
      count_q <= count_q + CNT_W'(1);
  end

  assign MulResultW = result_q;
  assign MulValidW  = valid_q;
  assign MulCountW  = count_q;

endmodule

// File: tb/tb_mul_writeback.sv
// Directed self-checking bench for mul_writeback at XLEN=64.
module tb_mul_writeback;

  localparam int unsigned XLEN = 64;

  logic              clk;
  logic              reset;
  logic              StallW;
  logic              FlushW;
  logic [2*XLEN-1:0] ProdM;
  logic [2:0]        Funct3M;
  logic              W64M;
  logic              MulValidM;
  logic [XLEN-1:0]   MulResultW;
  logic              MulValidW;
  logic [31:0]       MulCountW;

  int checks = 0;
  int errors = 0;

  mul_writeback #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ProdM      (ProdM),
    .Funct3M    (Funct3M),
    .W64M       (W64M),
    .MulValidM  (MulValidM),
    .MulResultW (MulResultW),
    .MulValidW  (MulValidW),
    .MulCountW  (MulCountW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] p, input logic [2:0] f3, input logic w64,
                       input logic v, input logic st, input logic fl);
    ProdM     = p;
    Funct3M   = f3;
    W64M      = w64;
    MulValidM = v;
    StallW    = st;
    FlushW    = fl;
  endtask

  task automatic check_out(input string tag, input logic [63:0] r, input logic v, input logic [31:0] c);
    check({tag, ".result"}, 128'(MulResultW), 128'(r));
    check({tag, ".valid"},  128'(MulValidW),  128'(v));
    check({tag, ".count"},  128'(MulCountW),  128'(c));
  endtask

  localparam logic [127:0] P_MUL = 128'h0000_0000_0000_0001_1234_5678_9ABC_DEF0;

  initial begin
    reset = 1'b0;
    drive(P_MUL, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    check_out("reset_async", 64'h0, 1'b0, 32'd0);
    step();
    check_out("reset_held", 64'h0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // mul low half
    step();
    check_out("mul", 64'h1234_5678_9ABC_DEF0, 1'b1, 32'd1);

    // mulh upper half
    drive(P_MUL, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("mulh", 64'h0000_0000_0000_0001, 1'b1, 32'd2);

    // mulw sign extension, upper product bits discarded
    drive(128'hDEAD_BEEF_0000_0000_1234_5678_8000_0000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_out("mulw", 64'hFFFF_FFFF_8000_0000, 1'b1, 32'd3);

    // W64M ignored for mulhu
    drive(128'hAAAA_BBBB_CCCC_DDDD_1234_5678_8000_0000, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_out("mulhu_w64", 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 32'd4);

    // non-multiply funct3 with valid high
    drive(P_MUL, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("notmul", 64'h0, 1'b0, 32'd4);

    // invalid mul still selects data but does not count
    drive(P_MUL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("invalid", 64'h1234_5678_9ABC_DEF0, 1'b0, 32'd4);

    drive(P_MUL, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("mulhsu", 64'h0000_0000_0000_0001, 1'b1, 32'd5);

    // stall and flush together: flush wins, no count
    drive(P_MUL, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check_out("stall_flush", 64'h0, 1'b0, 32'd5);

    drive(128'h0000_0000_0000_0000_0000_0000_0000_0042, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("load", 64'h42, 1'b1, 32'd6);

    // stall alone for three cycles while inputs change
    for (int i = 0; i < 3; i++) begin
      drive(P_MUL, 3'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      step();
      check_out($sformatf("stall%0d", i), 64'h42, 1'b1, 32'd6);
    end

    // preload counter to all ones while stalled, then wrap
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    step();
    check("preload", 128'(MulCountW), 128'(32'hFFFF_FFFF));
    drive(P_MUL, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("wrap", 64'h1234_5678_9ABC_DEF0, 1'b1, 32'd0);

    // flush alone does not clear counter
    drive(P_MUL, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_out("flush", 64'h0, 1'b0, 32'd0);
    drive(P_MUL, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_out("refill", 64'h1234_5678_9ABC_DEF0, 1'b1, 32'd1);

    // mid-cycle reset with a live result
    #2;
    reset = 1'b0;
    #1;
    check_out("midreset", 64'h0, 1'b0, 32'd0);
    step();
    check_out("midreset_edge", 64'h0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_out("post_reset", 64'h1234_5678_9ABC_DEF0, 1'b1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
